rand_sched: RTL and testbench

Round-robin scheduler that shares a single external `rand_gen` 8-bit LFSR between `N` requesters. It seeds the LFSR after reset and on demand, substitutes a safe seed for zero, and hands each granted requester one registered LFSR sample. It sits between the `rand_gen` instance and game-logic consumers such as spawners and AI, so no consumer ever drives `rand_gen` directly.

---
 rtl/rand_sched.sv | 100 ++++++++++
 tb/tb_rand_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rand_sched.sv
// rand_sched: round-robin sharing of one external 8-bit LFSR among N requesters, with seeding and reseed.
// Optional RAND_SCHED_LOCKUP_EN reseeds from SEED when the LFSR reads zero in SERVE.
module rand_sched #(
  parameter int         N    = 4,
  parameter logic [7:0] SEED = 8'hF0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         reseed,
  input  logic [7:0]   seed_in,
  input  logic [7:0]   lfsr_rand,
  output logic         lfsr_load,
  output logic [7:0]   lfsr_seed,
  output logic [N-1:0] gnt,
  output logic [7:0]   rand_out,
  output logic         rand_valid,
  output logic         ready
);
  localparam int PW = $clog2(N);
  typedef enum logic [1:0] {INIT, LOAD, SETTLE, SERVE} state_t;
  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d, idx, win;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [7:0]     rand_q, rand_d, seed_q, seed_d;
  logic           valid_q, load_q, ready_q, hit, lockup;
`ifdef RAND_SCHED_LOCKUP_EN
  assign lockup = lfsr_rand == 8'h00;
`else
  assign lockup = 1'b0;
`endif
  // first requester at or after ptr, wrapping
  always_comb begin
    hit = 1'b0;
    win = ptr_q;
    idx = ptr_q;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    rand_d  = rand_q;
    seed_d  = seed_q;
    case (state_q)
      INIT: begin
        state_d = LOAD;
        seed_d  = SEED;
      end
      LOAD:   state_d = SETTLE;
      SETTLE: state_d = SERVE;
      SERVE: begin
        if (reseed) begin
          state_d = LOAD;
          seed_d  = (seed_in == 8'h00) ? SEED : seed_in;
        end else if (lockup) begin
          state_d = LOAD;
          seed_d  = SEED;
        end else if (hit) begin
          gnt_d  = N'(1) << win;
          rand_d = lfsr_rand;
          ptr_d  = PW'((int'(win) + 1) % N);
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rand_q  <= 8'h00;
      seed_q  <= SEED;
      valid_q <= 1'b0;
      load_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rand_q  <= rand_d;
      seed_q  <= seed_d;
      valid_q <= |gnt_d;
      load_q  <= state_d == LOAD;
      ready_q <= state_d == SERVE;
    end
  end
  assign gnt        = gnt_q;
  assign rand_out   = rand_q;
  assign rand_valid = valid_q;
  assign lfsr_load  = load_q;
  assign lfsr_seed  = seed_q;
  assign ready      = ready_q;
endmodule

// File: tb/tb_rand_sched.sv
// tb_rand_sched: drives rand_sched with a Galois LFSR (taps 0x71) standing in for rand_gen and checks it against a cycle model.
module tb_rand_sched;
  localparam int N = 4;
  localparam logic [7:0] SEED = 8'hF0;
  logic clk = 1'b0;
  logic rst, reseed, force_zero;
  logic [N-1:0] req, gnt;
  logic [7:0] seed_in, lfsr_rand, lfsr_seed, rand_out, lfsr_q;
  logic lfsr_load, rand_valid, ready;
  int total = 0, bad = 0;
  int m_wait, m_ptr;
  logic [N-1:0] m_gnt;
  logic [7:0] m_rand, m_seed;
  logic [7:0] prev;
  always #5 clk = ~clk;
  rand_sched #(.N(N), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .req(req), .reseed(reseed), .seed_in(seed_in),
    .lfsr_rand(lfsr_rand), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
    .gnt(gnt), .rand_out(rand_out), .rand_valid(rand_valid), .ready(ready)
  );
  function automatic logic [7:0] lstep(input logic [7:0] q);
    return {q[6:0], 1'b0} ^ (q[7] ? 8'h71 : 8'h00);
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= 8'h01;
    else lfsr_q <= lfsr_load ? lfsr_seed : lstep(lfsr_q);
  assign lfsr_rand = force_zero ? 8'h00 : lfsr_q;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_wait = 3; m_ptr = 0; m_gnt = '0; m_rand = 8'h00; m_seed = SEED;
  endtask
  // call at a negedge; returns at the following negedge
  task automatic step(input logic [N-1:0] r, input logic rs, input logic [7:0] si, input logic fz);
    bit zero_lock;
    req = r; reseed = rs; seed_in = si; force_zero = fz;
    #1;
`ifdef RAND_SCHED_LOCKUP_EN
    zero_lock = lfsr_rand == 8'h00;
`else
    zero_lock = 0;
`endif
    m_gnt = '0;
    if (m_wait > 0) begin
      m_wait--;
    end else if (rs) begin
      m_wait = 2; m_seed = (si == 8'h00) ? SEED : si;
    end else if (zero_lock) begin
      m_wait = 2; m_seed = SEED;
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (m_gnt == '0 && r[k]) begin
          m_gnt = N'(1) << k; m_rand = lfsr_rand; m_ptr = (k + 1) % N;
        end
      end
    end
    @(posedge clk); #1;
    chk("gnt", gnt, m_gnt);
    chk("rand_out", rand_out, m_rand);
    chk("rand_valid", rand_valid, m_gnt != '0);
    chk("lfsr_load", lfsr_load, m_wait == 2);
    chk("lfsr_seed", lfsr_seed, m_seed);
    chk("ready", ready, m_wait == 0);
    chk("onehot", $onehot0(gnt), 1);
    @(negedge clk);
  endtask
  initial begin
    rst = 1; req = '0; reseed = 0; seed_in = 8'h00; force_zero = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rand", rand_out, 8'h00);
    chk("rst_valid", rand_valid, 0);
    chk("rst_load", lfsr_load, 0);
    chk("rst_seed", lfsr_seed, SEED);
    chk("rst_ready", ready, 0);
    rst = 0;
    step(4'b0001, 0, 8'h00, 0);
    chk("boot_load", lfsr_load, 1);
    step(4'b0001, 0, 8'h00, 0);
    step(4'b0001, 0, 8'h00, 0);
    chk("boot_ready", ready, 1);
    step(4'b0001, 0, 8'h00, 0);
    chk("boot_gnt", gnt, 4'b0001);
    chk("boot_rand", rand_out, 8'h91);
    prev = rand_out;
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 0, 8'h00, 0);
      chk("rr_order", gnt, 4'b0001 << ((i + 1) % 4));
      chk("rr_distinct", rand_out != prev, 1);
      prev = rand_out;
    end
    step(4'b1111, 1, 8'h00, 0);
    chk("rs0_seed", lfsr_seed, 8'hF0);
    chk("rs0_load", lfsr_load, 1);
    chk("rs0_gnt", gnt, 0);
    step(4'b1111, 0, 8'h00, 0);
    chk("rs0_load_off", lfsr_load, 0);
    chk("rs0_ready", ready, 0);
    step(4'b0000, 0, 8'h00, 0);
    step(4'b0100, 1, 8'h5A, 0);
    chk("rs5a_nogrant", gnt, 0);
    step(4'b0100, 0, 8'h00, 0);
    step(4'b0100, 0, 8'h00, 0);
    chk("rs5a_settle_nogrant", gnt, 0);
    step(4'b0100, 0, 8'h00, 0);
    chk("rs5a_gnt", gnt, 4'b0100);
    chk("rs5a_rand", rand_out, 8'hB4);
    step(4'b0010, 0, 8'h00, 1);
`ifdef RAND_SCHED_LOCKUP_EN
    chk("lock_gnt", gnt, 0);
    chk("lock_load", lfsr_load, 1);
    chk("lock_seed", lfsr_seed, 8'hF0);
`else
    chk("zero_gnt", gnt, 4'b0010);
    chk("zero_rand", rand_out, 8'h00);
`endif
    repeat (3) step(4'b0000, 0, 8'h00, 0);
    step(4'b1111, 0, 8'h00, 0);
    chk("pre_rst_gnt", gnt != 0, 1);
    rst = 1;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_valid", rand_valid, 0);
    chk("arst_rand", rand_out, 8'h00);
    chk("arst_ready", ready, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    repeat (4) step(4'b0001, 0, 8'h00, 0);
    chk("reboot_rand", rand_out, 8'h91);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] s;
      s = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      step(N'($urandom), $urandom_range(15) == 0, s, $urandom_range(19) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
